// File: rtl/mw_mem_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mw_mem_write_ctrl_pkg
//   Shared definitions for the MW memory-write sequencer. This package holds
//   the FSM state encoding, the store-size codes and the lane-mask lookup.
//   It takes the place of a separate defines include.
//   Optional feature macro used by the sequencer: MW_WR_SPLIT_EN.
// -----------------------------------------------------------------------------
package mw_mem_write_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ1 = 2'd1,
      ST_REQ2 = 2'd2,
      ST_DONE = 2'd3
   } mw_state_e;

   localparam logic [1:0] SIZE_BYTE  = 2'b00;
   localparam logic [1:0] SIZE_WORD  = 2'b01;
   localparam logic [1:0] SIZE_DWORD = 2'b10;

   // Byte-lane mask of a store before it is shifted by the address offset.
   // The reserved size code 11 is treated as a dword.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      case (size)
         SIZE_BYTE: lane_mask = 4'b0001;
         SIZE_WORD: lane_mask = 4'b0011;
         default:   lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mw_mem_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// mw_mem_write_ctrl_if
//   This interface groups the MW-side store request and the data-memory bus.
//   slave  : the sequencer's view
//            inputs  v_mem_we, wr_addr, wr_data, wr_size, flush, mem_ack
//            outputs mem_req, mem_addr, mem_wdata, mem_be,
//                    write_finished, wr_misalign, busy
//   master : the environment's view, which drives the MW request and the bus ack
// -----------------------------------------------------------------------------
interface mw_mem_write_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              v_mem_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        wr_size;
   logic              flush;
   logic              mem_ack;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              write_finished;
   logic              wr_misalign;
   logic              busy;

   modport slave (
      input  v_mem_we, wr_addr, wr_data, wr_size, flush, mem_ack,
      output mem_req, mem_addr, mem_wdata, mem_be, write_finished, wr_misalign, busy
   );

   modport master (
      output v_mem_we, wr_addr, wr_data, wr_size, flush, mem_ack,
      input  mem_req, mem_addr, mem_wdata, mem_be, write_finished, wr_misalign, busy
   );
endinterface

// File: rtl/mw_mem_write_ctrl_wr_align.sv
// -----------------------------------------------------------------------------
// mw_wr_align
//   This block is purely combinational. It turns a store's address, data and
//   size into the bus fields of the first dword access and of the second one.
//   need2 flags a store whose lanes spill past the first dword.
//   Inputs : addr_i, data_i (right-justified), size_i
//   Outputs: addr1_o, be1_o, wdata1_o, addr2_o, be2_o, wdata2_o, need2_o
// -----------------------------------------------------------------------------
module mw_wr_align
   import mw_mem_write_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       data_i,
   input  logic [1:0]        size_i,
   output logic [ADDR_W-1:0] addr1_o,
   output logic [3:0]        be1_o,
   output logic [31:0]       wdata1_o,
   output logic [ADDR_W-1:0] addr2_o,
   output logic [3:0]        be2_o,
   output logic [31:0]       wdata2_o,
   output logic              need2_o
);
   logic [1:0]  off;
   logic [6:0]  wide;
   logic [55:0] d;

   assign off  = addr_i[1:0];
   // A dword at offset 3 reaches lane 6, so the mask needs 7 bits and the data needs 56.
   assign wide = {3'b000, lane_mask(size_i)} << off;
   assign d    = {24'h0, data_i} << {off, 3'b000};

   assign addr1_o  = {addr_i[ADDR_W-1:2], 2'b00};
   assign be1_o    = wide[3:0];
   assign wdata1_o = d[31:0];
   // The second access always targets the next dword and wraps at the top of the space.
   assign addr2_o  = addr1_o + ADDR_W'(4);
   assign be2_o    = {1'b0, wide[6:4]};
   assign wdata2_o = {8'h00, d[55:32]};
   assign need2_o  = |wide[6:4];
endmodule

// File: rtl/mw_mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// mw_mem_write_ctrl
//   This is the memory-write sequencer that sits after the MW stage. It
//   captures one store and drives the data-memory bus handshake. It pulses
//   write_finished once the store is committed, which releases the MW stall.
//   Ports: clk, rst (synchronous, active high), bus (mw_mem_write_ctrl_if.slave).
//   Option MW_WR_SPLIT_EN:
//     defined   -> a store that crosses a dword boundary is issued as two bus writes.
//     undefined -> such a store is not issued to the bus. wr_misalign and
//                  write_finished both pulse instead.
// -----------------------------------------------------------------------------
module mw_mem_write_ctrl
   import mw_mem_write_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   mw_mem_write_ctrl_if.slave bus
);
`ifdef MW_WR_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   mw_state_e         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        size_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [3:0]        mem_be_q;
   logic              fin_q;
   logic              mis_q;
   logic              busy_q;

   logic [ADDR_W-1:0] al_addr, a1, a2;
   logic [DATA_W-1:0] al_data, w1, w2;
   logic [1:0]        al_size;
   logic [3:0]        be1, be2;
   logic              need2;

   // In IDLE the aligner looks at the live request, so the first access can be
   // registered on the capture edge. After that it looks at the captured store.
   assign al_addr = (state_q == ST_IDLE) ? bus.wr_addr : addr_q;
   assign al_data = (state_q == ST_IDLE) ? bus.wr_data : data_q;
   assign al_size = (state_q == ST_IDLE) ? bus.wr_size : size_q;

   mw_wr_align #(.ADDR_W(ADDR_W)) u_align (
      .addr_i  (al_addr),
      .data_i  (al_data),
      .size_i  (al_size),
      .addr1_o (a1),
      .be1_o   (be1),
      .wdata1_o(w1),
      .addr2_o (a2),
      .be2_o   (be2),
      .wdata2_o(w2),
      .need2_o (need2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         size_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         fin_q       <= 1'b0;
         mis_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         fin_q <= 1'b0;
         mis_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.v_mem_we && !bus.flush) begin
                  addr_q <= bus.wr_addr;
                  data_q <= bus.wr_data;
                  size_q <= bus.wr_size;
                  busy_q <= 1'b1;
                  if (need2 && !SPLIT_EN) begin
                     // A crossing store cannot be issued. MW retires it and the fault is raised upstream.
                     state_q <= ST_DONE;
                     fin_q   <= 1'b1;
                     mis_q   <= 1'b1;
                  end else begin
                     state_q     <= ST_REQ1;
                     mem_req_q   <= 1'b1;
                     mem_addr_q  <= a1;
                     mem_wdata_q <= w1;
                     mem_be_q    <= be1;
                  end
               end
            end
            ST_REQ1: begin
               if (bus.mem_ack) begin
                  if (need2 && SPLIT_EN) begin
                     state_q     <= ST_REQ2;
                     mem_addr_q  <= a2;
                     mem_wdata_q <= w2;
                     mem_be_q    <= be2;
                  end else begin
                     state_q   <= ST_DONE;
                     mem_req_q <= 1'b0;
                     mem_be_q  <= '0;
                     fin_q     <= 1'b1;
                  end
               end
            end
            ST_REQ2: begin
               if (bus.mem_ack) begin
                  state_q   <= ST_DONE;
                  mem_req_q <= 1'b0;
                  mem_be_q  <= '0;
                  fin_q     <= 1'b1;
               end
            end
            ST_DONE: begin
               // MW still holds v_mem_we for the retiring store in this cycle, so no capture happens here.
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_req        = mem_req_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.mem_be         = mem_be_q;
   assign bus.write_finished = fin_q;
   assign bus.wr_misalign    = mis_q;
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_mw_mem_write_ctrl.sv
module tb_mw_mem_write_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   mw_mem_write_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mw_mem_write_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      bus.v_mem_we = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      bus.wr_size  = s;
   endtask

   initial begin
      rst = 1'b1;
      bus.v_mem_we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_size = 2'b00;
      bus.flush = 1'b0; bus.mem_ack = 1'b1;
      tick(); tick();
      check("rst_req", bus.mem_req, 0);
      check("rst_be", bus.mem_be, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_fin", bus.write_finished, 0);
      check("rst_mis", bus.wr_misalign, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;
      tick();

      // 1: aligned dword with immediate ack. The pulse arrives in the third cycle.
      req(32'h1000, 32'hDEADBEEF, 2'b10);
      tick();
      check("t1_req", bus.mem_req, 1);
      check("t1_addr", bus.mem_addr, 32'h1000);
      check("t1_be", bus.mem_be, 4'hF);
      check("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
      check("t1_fin_early", bus.write_finished, 0);
      check("t1_busy", bus.busy, 1);
      tick();
      check("t1_fin", bus.write_finished, 1);
      check("t1_req_off", bus.mem_req, 0);
      bus.v_mem_we = 1'b0;
      tick();
      check("t1_fin_once", bus.write_finished, 0);
      check("t1_idle", bus.busy, 0);

      // 2: byte store into the top lane
      req(32'h2003, 32'h0000005A, 2'b00);
      tick();
      check("t2_addr", bus.mem_addr, 32'h2000);
      check("t2_be", bus.mem_be, 4'b1000);
      check("t2_wdata", bus.mem_wdata, 32'h5A000000);
      tick();
      check("t2_fin", bus.write_finished, 1);
      bus.v_mem_we = 1'b0;
      tick();

      // 3: dword at offset 2 crosses into the next dword
      req(32'h3002, 32'h11223344, 2'b10);
      tick();
`ifdef MW_WR_SPLIT_EN
      check("t3_r1_req", bus.mem_req, 1);
      check("t3_r1_addr", bus.mem_addr, 32'h3000);
      check("t3_r1_be", bus.mem_be, 4'b1100);
      check("t3_r1_wdata", bus.mem_wdata, 32'h33440000);
      check("t3_r1_fin", bus.write_finished, 0);
      tick();
      check("t3_r2_req", bus.mem_req, 1);
      check("t3_r2_addr", bus.mem_addr, 32'h3004);
      check("t3_r2_be", bus.mem_be, 4'b0011);
      check("t3_r2_wdata", bus.mem_wdata, 32'h00001122);
      check("t3_r2_fin", bus.write_finished, 0);
      tick();
      check("t3_fin", bus.write_finished, 1);
      check("t3_mis", bus.wr_misalign, 0);
`else
      check("t3_noreq", bus.mem_req, 0);
      check("t3_fin", bus.write_finished, 1);
      check("t3_mis", bus.wr_misalign, 1);
`endif
      bus.v_mem_we = 1'b0;
      tick();
      check("t3_fin_once", bus.write_finished, 0);

      // 4: ack withheld for 5 cycles in REQ1, so the bus fields must stay stable
      bus.mem_ack = 1'b0;
      req(32'h5000, 32'hCAFEF00D, 2'b10);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_req", bus.mem_req, 1);
         check("t4_addr", bus.mem_addr, 32'h5000);
         check("t4_wdata", bus.mem_wdata, 32'hCAFEF00D);
         check("t4_be", bus.mem_be, 4'hF);
         check("t4_nofin", bus.write_finished, 0);
         tick();
      end
      bus.mem_ack = 1'b1;
      tick();
      check("t4_fin", bus.write_finished, 1);
      bus.v_mem_we = 1'b0;
      tick();

      // 5: flush blocks capture in IDLE, but a store already issued still completes
      bus.flush = 1'b1;
      req(32'h6000, 32'h01020304, 2'b10);
      tick();
      check("t5_flush_req", bus.mem_req, 0);
      check("t5_flush_busy", bus.busy, 0);
      bus.flush = 1'b0;
      bus.mem_ack = 1'b0;
      tick();
      check("t5_cap_req", bus.mem_req, 1);
      bus.flush = 1'b1;
      tick();
      check("t5_keep_req", bus.mem_req, 1);
      check("t5_keep_busy", bus.busy, 1);
      bus.mem_ack = 1'b1;
      tick();
      check("t5_fin", bus.write_finished, 1);
      bus.flush = 1'b0;
      bus.v_mem_we = 1'b0;
      tick();

      // 6: word at offset 3 crosses the dword boundary
      req(32'h4003, 32'h0000BEEF, 2'b01);
      tick();
`ifdef MW_WR_SPLIT_EN
      check("t6_r1_be", bus.mem_be, 4'b1000);
      check("t6_r1_wdata", bus.mem_wdata, 32'hEF000000);
      tick();
      check("t6_r2_addr", bus.mem_addr, 32'h4004);
      check("t6_r2_be", bus.mem_be, 4'b0001);
      check("t6_r2_wdata", bus.mem_wdata, 32'h000000BE);
      tick();
      check("t6_fin", bus.write_finished, 1);
`else
      check("t6_noreq", bus.mem_req, 0);
      check("t6_fin", bus.write_finished, 1);
      check("t6_mis", bus.wr_misalign, 1);
`endif
      bus.v_mem_we = 1'b0;
      tick();
      check("t6_mis_once", bus.wr_misalign, 0);

      // Reset mid-transfer: REQ2 when splitting is enabled, otherwise REQ1
      bus.mem_ack = 1'b0;
`ifdef MW_WR_SPLIT_EN
      req(32'h7002, 32'hA5A5A5A5, 2'b10);
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("rst2_in_req2", bus.mem_addr, 32'h7004);
`else
      req(32'h7000, 32'hA5A5A5A5, 2'b10);
      tick();
`endif
      check("rstmid_req_before", bus.mem_req, 1);
      rst = 1'b1;
      tick();
      check("rstmid_req", bus.mem_req, 0);
      check("rstmid_busy", bus.busy, 0);
      check("rstmid_be", bus.mem_be, 0);
      rst = 1'b0;
      bus.v_mem_we = 1'b0;
      bus.mem_ack = 1'b1;
      tick();
      check("post_rst_idle", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
